fetch_requester: RTL and testbench

FETCH_REQUESTER -- requirements
Module: fetch_requester

---
 rtl/p_hardisc.sv | 29 ++
 rtl/fetch_requester_if.sv | 25 ++
 rtl/fetch_credit.sv | 26 ++
 rtl/seu_ff_rst.sv | 21 ++
 rtl/fetch_requester.sv | 116 +++++++++++
 tb/tb_fetch_requester.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/p_hardisc.sv
// Shared project definitions for the fetch path.
// Holds the fetch-buffer entry layout (width, bit-field positions), the entry
// status codes, the outstanding/discard counter width and the requester FSM
// state type.
package p_hardisc;

    // Fetch-buffer entry: [31:0] data, [32] compressed flag,
    // [35:33] fetch status, [37:36] prediction bits.
    localparam int unsigned IFB_WIDTH    = 38;
    localparam int unsigned IFB_DATA_LSB = 0;
    localparam int unsigned IFB_DATA_MSB = 31;
    localparam int unsigned IFB_RVC_BIT  = 32;
    localparam int unsigned IFB_INFO_LSB = 33;
    localparam int unsigned IFB_INFO_MSB = 35;
    localparam int unsigned IFB_PRED_LSB = 36;
    localparam int unsigned IFB_PRED_MSB = 37;

    localparam logic [2:0] FETCH_VALID = 3'b001;
    localparam logic [2:0] FETCH_BSERR = 3'b010;

    // Wide enough for MAX_OUT up to 3.
    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StFetch = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_requester_if.sv
// Instruction bus between the fetch requester (master) and memory (slave).
//   req/addr       : address phase, addr held until gnt
//   gnt            : address accepted this cycle
//   rvalid/rdata   : response phase, one response per granted request, in order
//   rerr           : bus error on this response
//   rchecksum      : SECDED checksum of rdata
interface fetch_requester_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
    logic [6:0]  rchecksum;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, rerr, rchecksum
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, rerr, rchecksum
    );
endinterface

// File: rtl/fetch_credit.sv
// Free fetch-buffer slots not yet claimed by in-flight requests.
//   s_occupied_i    : per-entry occupancy of the fetch buffer
//   s_outstanding_i : bus requests granted but not yet answered
//   s_credit_o      : IFB_SIZE - popcount(occupied) - outstanding (signed)
module fetch_credit
    import p_hardisc::*;
#(
    parameter int unsigned IFB_SIZE = 2
) (
    input  logic [IFB_SIZE-1:0] s_occupied_i,
    input  logic [CNT_W-1:0]    s_outstanding_i,
    output logic signed [3:0]   s_credit_o
);
    logic [2:0] popcount;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < int'(IFB_SIZE); i++) begin
            popcount = popcount + 3'(s_occupied_i[i]);
        end
    end

    // Can go negative when the buffer reports more entries than expected.
    assign s_credit_o = $signed(4'(IFB_SIZE)) - $signed({1'b0, popcount})
                      - $signed(4'(s_outstanding_i));
endmodule

// File: rtl/seu_ff_rst.sv
// Register wrapper with asynchronous active-high reset, used for all
// architectural state so it can later be swapped for a hardened cell.
//   s_c_i : clock        s_r_i : async reset (active high)
//   s_d_i : next value   s_q_o : registered value (RSTVAL while in reset)
module seu_ff_rst #(
    parameter int unsigned   W      = 1,
    parameter logic [W-1:0]  RSTVAL = '0
) (
    input  logic         s_c_i,
    input  logic         s_r_i,
    input  logic [W-1:0] s_d_i,
    output logic [W-1:0] s_q_o
);
    always_ff @(posedge s_c_i or posedge s_r_i) begin
        if (s_r_i) begin
            s_q_o <= RSTVAL;
        end else begin
            s_q_o <= s_d_i;
        end
    end
endmodule

// File: rtl/fetch_requester.sv
// Instruction fetch requester: issues word-aligned fetches on the bus while
// the fetch buffer has room, pushes responses straight into the buffer and
// drops responses belonging to requests issued before a redirect.
//   s_clk_i, s_reset_i : clock, async active-high reset
//   s_start_i          : leave IDLE, start fetching at the current address
//   s_flush_i/_addr_i  : redirect to a new address
//   bus                : instruction bus (master side)
//   s_push_o/data/chk  : fetch-buffer write port (zero latency from response)
//   s_occupied_i       : fetch-buffer occupancy
module fetch_requester
    import p_hardisc::*;
#(
    parameter int unsigned IFB_SIZE  = 2,
    parameter int unsigned MAX_OUT   = 2,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic                 s_clk_i,
    input  logic                 s_reset_i,
    input  logic                 s_start_i,
    input  logic                 s_flush_i,
    input  logic [31:0]          s_flush_addr_i,
    fetch_requester_if.master    bus,
    output logic                 s_push_o,
    output logic [IFB_WIDTH-1:0] s_data_o,
    output logic [6:0]           s_checksum_o,
    input  logic [IFB_SIZE-1:0]  s_occupied_i
);
    fetch_state_t      state_q, state_d;
    logic              state_raw;
    logic [31:0]       addr_q, addr_d;
    logic [CNT_W-1:0]  out_q, out_d;
    logic [CNT_W-1:0]  disc_q, disc_d;
    logic signed [3:0] credit;
    logic [31:0]       flush_addr;
    logic              grant;
    logic              resp;
    logic              drop;

    fetch_credit #(.IFB_SIZE(IFB_SIZE)) u_credit (
        .s_occupied_i    (s_occupied_i),
        .s_outstanding_i (out_q),
        .s_credit_o      (credit)
    );

    seu_ff_rst #(.W(1), .RSTVAL(1'b0)) u_state_ff (
        .s_c_i (s_clk_i), .s_r_i (s_reset_i), .s_d_i (state_d), .s_q_o (state_raw)
    );
    seu_ff_rst #(.W(32), .RSTVAL(BOOT_ADDR)) u_addr_ff (
        .s_c_i (s_clk_i), .s_r_i (s_reset_i), .s_d_i (addr_d), .s_q_o (addr_q)
    );
    seu_ff_rst #(.W(CNT_W), .RSTVAL('0)) u_out_ff (
        .s_c_i (s_clk_i), .s_r_i (s_reset_i), .s_d_i (out_d), .s_q_o (out_q)
    );
    seu_ff_rst #(.W(CNT_W), .RSTVAL('0)) u_disc_ff (
        .s_c_i (s_clk_i), .s_r_i (s_reset_i), .s_d_i (disc_d), .s_q_o (disc_q)
    );

    assign state_q    = fetch_state_t'(state_raw);
    assign flush_addr = s_flush_addr_i & 32'hFFFF_FFFC;
    assign bus.addr   = addr_q;

    // A response with nothing outstanding is stray (e.g. from before reset).
    assign resp  = bus.rvalid && (out_q != '0);
    assign grant = bus.req && bus.gnt;
    // A response in the redirect cycle is already stale.
    assign drop  = s_flush_i || (disc_q != '0);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        out_d        = out_q;
        disc_d       = disc_q;
        bus.req      = 1'b0;
        s_push_o     = 1'b0;
        s_data_o     = '0;
        s_checksum_o = '0;

        if (state_q == StIdle && s_start_i) begin
            state_d = StFetch;
        end

        if (state_q == StFetch && credit > 0 && out_q < CNT_W'(MAX_OUT) && !s_flush_i) begin
            bus.req = 1'b1;
        end

        out_d = out_q + CNT_W'(grant) - CNT_W'(resp);

        if (s_flush_i) begin
            addr_d = flush_addr;
            disc_d = out_q - CNT_W'(resp);
        end else begin
            if (grant) begin
                addr_d = addr_q + 32'd4;
            end
            if (resp && disc_q != '0) begin
                disc_d = disc_q - CNT_W'(1);
            end
        end

        if (resp && !drop) begin
            s_push_o                           = 1'b1;
            s_data_o[IFB_RVC_BIT]              = 1'b0;
            s_data_o[IFB_PRED_MSB:IFB_PRED_LSB] = 2'b00;
            if (bus.rerr) begin
                s_data_o[IFB_INFO_MSB:IFB_INFO_LSB] = FETCH_BSERR;
            end else begin
                s_data_o[IFB_DATA_MSB:IFB_DATA_LSB] = bus.rdata;
                s_data_o[IFB_INFO_MSB:IFB_INFO_LSB] = FETCH_VALID;
                s_checksum_o                        = bus.rchecksum;
            end
        end
    end

    stray_response: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        !(bus.rvalid && out_q == '0));
endmodule

// File: tb/tb_fetch_requester.sv
module tb_fetch_requester;
    import p_hardisc::*;

    localparam int unsigned IFB_SIZE  = 2;
    localparam int unsigned MAX_OUT   = 2;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_start;
    logic                 s_flush;
    logic [31:0]          s_flush_addr;
    logic                 s_push;
    logic [IFB_WIDTH-1:0] s_data;
    logic [6:0]           s_checksum;
    logic [IFB_SIZE-1:0]  s_occupied;

    fetch_requester_if bus_if ();

    fetch_requester #(
        .IFB_SIZE  (IFB_SIZE),
        .MAX_OUT   (MAX_OUT),
        .BOOT_ADDR (BOOT_ADDR)
    ) dut (
        .s_clk_i        (clk),
        .s_reset_i      (rst),
        .s_start_i      (s_start),
        .s_flush_i      (s_flush),
        .s_flush_addr_i (s_flush_addr),
        .bus            (bus_if),
        .s_push_o       (s_push),
        .s_data_o       (s_data),
        .s_checksum_o   (s_checksum),
        .s_occupied_i   (s_occupied)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of issued fetches in issue order, each tagged
    // stale once a redirect happens while it is in flight.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       m_q[$];
    bit          m_fetching;
    logic [31:0] m_pc;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fetching = 1'b0;
        m_pc       = BOOT_ADDR;
        m_q.delete();
    endtask

    // One clock cycle: drive inputs, compare outputs against the model at the
    // falling edge, advance the model, then move just past the rising edge.
    // rv asks for a response; it is only given if something is in flight.
    task automatic cyc(input bit st, input bit fl, input logic [31:0] fla, input bit g,
                       input bit rv, input bit re, input logic [IFB_SIZE-1:0] occ);
        bit             resp;
        bit             req_e;
        bit             push_e;
        int             credit;
        logic [31:0]    rd;
        logic [6:0]     ck;
        logic [37:0]    data_e;
        logic [6:0]     ck_e;

        resp = rv && (m_q.size() != 0);
        rd   = resp ? mem_word(m_q[0].addr) : $urandom;
        ck   = 7'($urandom);

        s_start          = st;
        s_flush          = fl;
        s_flush_addr     = fla;
        s_occupied       = occ;
        bus_if.gnt       = g;
        bus_if.rvalid    = resp;
        bus_if.rerr      = resp && re;
        bus_if.rdata     = rd;
        bus_if.rchecksum = ck;

        credit = int'(IFB_SIZE) - $countones(occ) - m_q.size();
        req_e  = m_fetching && credit > 0 && m_q.size() < int'(MAX_OUT) && !fl;
        push_e = 1'b0;
        if (resp) push_e = !m_q[0].stale && !fl;
        data_e = '0;
        ck_e   = '0;
        if (push_e) begin
            if (re) begin
                data_e = {2'b00, FETCH_BSERR, 1'b0, 32'h0};
            end else begin
                data_e = {2'b00, FETCH_VALID, 1'b0, rd};
                ck_e   = ck;
            end
        end

        @(negedge clk);
        chk("req", 64'(bus_if.req), 64'(req_e));
        chk("addr", 64'(bus_if.addr), 64'(m_pc));
        chk("push", 64'(s_push), 64'(push_e));
        chk("data", 64'(s_data), 64'(data_e));
        chk("checksum", 64'(s_checksum), 64'(ck_e));

        if (resp) void'(m_q.pop_front());
        if (req_e && g) begin
            m_q.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (fl) begin
            foreach (m_q[i]) m_q[i].stale = 1'b1;
            m_pc = {fla[31:2], 2'b00};
        end
        if (st) m_fetching = 1'b1;

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        s_start          = 1'b0;
        s_flush          = 1'b0;
        s_flush_addr     = '0;
        s_occupied       = '0;
        bus_if.gnt       = 1'b0;
        bus_if.rvalid    = 1'b0;
        bus_if.rerr      = 1'b0;
        bus_if.rdata     = '0;
        bus_if.rchecksum = '0;
        m_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(bus_if.req), 64'(0));
        chk("rst_addr", 64'(bus_if.addr), 64'(BOOT_ADDR));
        chk("rst_push", 64'(s_push), 64'(0));
        chk("rst_data", 64'(s_data), 64'(0));
        chk("rst_checksum", 64'(s_checksum), 64'(0));
        rst = 1'b0;

        // Idle: no requests even with grant and empty buffer.
        repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);

        // Start, grant everything, answer one cycle after each grant.
        cyc(1, 0, 0, 1, 0, 0, '0);
        repeat (6) cyc(0, 0, 0, 1, 1, 0, '0);
        // Buffer partly full, no responses: requests stop at the credit limit.
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 2'b01);
        chk("credit_stop", 64'(m_q.size() + 1), 64'(IFB_SIZE));
        repeat (3) cyc(0, 0, 0, 0, 1, 0, '0);

        // Two in flight, redirect to 0x100: both answers dropped.
        repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);
        chk("two_out", 64'(m_q.size()), 64'(2));
        cyc(0, 1, 32'h0000_0100, 1, 0, 0, '0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, '0);

        // Bus error response.
        cyc(0, 0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 1, '0);

        // Address wrap; low flush address bits are ignored.
        cyc(0, 1, 32'hFFFF_FFFE, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, '0);
        chk("wrap_pc", 64'(m_pc), 64'(0));

        // Redirect coinciding with a response and a grant.
        repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);
        cyc(0, 1, 32'h0000_0200, 1, 1, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, '0);
        cyc(0, 0, 0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 0, '0);

        // Asynchronous reset with two in flight.
        repeat (2) cyc(0, 0, 0, 1, 0, 0, '0);
        bus_if.rvalid = 1'b1;
        rst = 1'b1;
        #2;
        chk("arst_req", 64'(bus_if.req), 64'(0));
        chk("arst_addr", 64'(bus_if.addr), 64'(BOOT_ADDR));
        chk("arst_push", 64'(s_push), 64'(0));
        chk("arst_data", 64'(s_data), 64'(0));
        chk("arst_checksum", 64'(s_checksum), 64'(0));
        bus_if.rvalid = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0, 0, '0);

        // Redirect while idle only moves the start address.
        cyc(0, 1, 32'h0000_0040, 1, 0, 0, '0);
        cyc(1, 0, 0, 1, 0, 0, '0);
        repeat (3) cyc(0, 0, 0, 1, 1, 0, '0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 11) == 0),
                $urandom,
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 7) == 0),
                IFB_SIZE'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
